// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 (modified) Booth multiplier with a start/busy/done handshake.
// Retires one Booth digit per clock and supports signed or unsigned operands per operation.
module booth_radix4_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int EW    = WIDTH + 2;             // extended operand width
    localparam int PW    = WIDTH + 4;             // partial-product arithmetic width
    localparam int RW    = 2 * EW + 1;            // {accumulator high, multiplier/low product, window bit}
    localparam int NSTEP = WIDTH / 2 + 1;
    localparam int CW    = $clog2(NSTEP + 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t               state_q, state_d;
    logic [EW-1:0]        a_q, a_d;
    logic [RW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        step_q, step_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [EW-1:0]        a_ext;
    logic [EW-1:0]        b_ext;
    logic [PW-1:0]        a_wide;
    logic [PW-1:0]        a_dbl;
    logic [PW-1:0]        pp;
    logic [PW-1:0]        hi_wide;
    logic [PW-1:0]        sum;
    logic [RW-1:0]        stepped;

    assign a_ext = {{2{signed_mode & in_A[WIDTH-1]}}, in_A};
    assign b_ext = {{2{signed_mode & in_B[WIDTH-1]}}, in_B};

    assign a_wide = {{2{a_q[EW-1]}}, a_q};
    assign a_dbl  = {a_q[EW-1], a_q, 1'b0};

    // The low three bits of the combined register are the Booth window {b[2i+1], b[2i], b[2i-1]}.
    always_comb begin
        pp = '0;
        unique case (acc_q[2:0])
            3'b001, 3'b010: pp = a_wide;
            3'b011:         pp = a_dbl;
            3'b100:         pp = ~a_dbl + PW'(1);
            3'b101, 3'b110: pp = ~a_wide + PW'(1);
            default:        pp = '0;
        endcase
    end

    // Sign-extended high half plus digit, then the whole register shifts right by two.
    assign hi_wide = {{2{acc_q[RW-1]}}, acc_q[RW-1:RW-EW]};
    assign sum     = hi_wide + pp;
    assign stepped = {sum, acc_q[EW:2]};

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        acc_d     = acc_q;
        step_d    = step_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    a_d     = a_ext;
                    acc_d   = {{EW{1'b0}}, b_ext, 1'b0};
                    step_d  = '0;
                end
            end
            CALC: begin
                acc_d  = stepped;
                step_d = step_q + CW'(1);
                if (step_q == CW'(NSTEP - 1)) begin
                    state_d   = IDLE;
                    product_d = stepped[2*WIDTH:1];
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult (WIDTH=16): directed cases, handshake corners and random regression.
module tb_booth_radix4_mult;

    localparam int W     = 16;
    localparam int NSTEP = W / 2 + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic             signed_mode;
    logic [W-1:0]     in_A;
    logic [W-1:0]     in_B;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    booth_radix4_mult #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_mode(signed_mode),
        .in_A       (in_A),
        .in_B       (in_B),
        .busy       (busy),
        .done       (done),
        .product    (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y, p;
        if (sm) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = a;
            y = b;
        end
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("product", 64'(product), 64'(mon_e.prod));
                check("latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Called just after a rising edge; the start is sampled at the next edge.
    task automatic drive_start(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] exp, input bit expect_done);
        exp_t e;
        signed_mode = sm;
        in_A        = a;
        in_B        = b;
        start       = 1'b1;
        if (expect_done) begin
            e.prod = exp;
            e.cyc  = cyc + 1 + NSTEP;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic run_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        drive_start(sm, a, b, exp, 1'b1);
        wait_idle();
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        in_A        = '0;
        in_B        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_product", 64'(product), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Signed reference vector with cycle-by-cycle busy/done profile.
        drive_start(1'b1, 16'h8981, 16'h8555, 32'h38C7_ACD5, 1'b1);
        for (int i = 0; i < NSTEP; i++) begin
            @(negedge clk);
            check("busy_during_calc", 64'(busy), 64'(1));
            check("done_during_calc", 64'(done), 64'(0));
        end
        @(negedge clk);
        check("busy_at_done", 64'(busy), 64'(0));
        check("done_pulse", 64'(done), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("product_held", 64'(product), 64'(32'h38C7_ACD5));
        @(posedge clk);
        #1;

        run_op(1'b0, 16'h8981, 16'h8555, 32'h479D_ACD5);
        run_op(1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        run_op(1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_op(1'b1, 16'h0000, 16'hBEEF, 32'h0000_0000);
        run_op(1'b0, 16'h0000, 16'hABCD, 32'h0000_0000);
        run_op(1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000);
        run_op(1'b0, 16'h8000, 16'h8000, 32'h4000_0000);

        // Start while busy is ignored; a start held into the done cycle launches the next op.
        drive_start(1'b0, 16'h8981, 16'h8555, 32'h479D_ACD5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        signed_mode = 1'b1;
        in_A        = 16'h7FFF;
        in_B        = 16'h7FFF;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        signed_mode = 1'b1;
        in_A        = 16'h1234;
        in_B        = 16'hF0ED;
        start       = 1'b1;
        mon_e.prod  = ref_mul(1'b1, 16'h1234, 16'hF0ED);
        mon_e.cyc   = cyc + 2 + NSTEP;
        sb.push_back(mon_e);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'(1));
        wait_idle();

        // Reset for one edge during step 4 aborts the op with no done pulse.
        drive_start(1'b1, 16'h5A5A, 16'hA5A5, '0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_product", 64'(product), 64'(0));
        repeat (12) @(posedge clk);
        #1;
        run_op(1'b1, 16'h8981, 16'h8555, 32'h38C7_ACD5);

        // Random regression in both modes, each op launched in the previous done cycle.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 600; i++) begin
                ra = W'($urandom());
                rb = W'($urandom());
                run_op(m[0], ra, rb, ref_mul(m[0], ra, rb));
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
